// File: rtl/sdr_init_seq.sv
// SDRAM power-up sequencer: PWRUP NOP wait, PRE-all, NUM_AREF x AREF, MRS, then init_done.
// Latency: all outputs registered; command for a cycle is decided at the preceding clock edge.
// Backpressure: none; cfg_sdr_en low aborts to IDLE (DESELECT, cke=0) on the next edge.
//
// Ports:
//   clk, reset_n                    clock, async active-low reset
//   cfg_sdr_en                      start/hold enable
//   cfg_sdr_mode_reg                MRS value, sampled on the edge that issues MRS
//   cfg_sdr_trp_d, cfg_sdr_trcar_d  PRE / AREF spacing, latched at start (0 acts as 1)
//   sdr_init_done                   level, high while in DONE
//   sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr   SDRAM command bus
module sdr_init_seq #(
    parameter int PWRUP_CYC  = 100,
    parameter int NUM_AREF   = 2,
    parameter int TMRD       = 2,
    parameter int SDR_ADDR_W = 13
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_sdr_en,
    input  logic [12:0]           cfg_sdr_mode_reg,
    input  logic [3:0]            cfg_sdr_trp_d,
    input  logic [3:0]            cfg_sdr_trcar_d,
    output logic                  sdr_init_done,
    output logic                  sdr_cke,
    output logic                  sdr_cs_n,
    output logic                  sdr_ras_n,
    output logic                  sdr_cas_n,
    output logic                  sdr_we_n,
    output logic [1:0]            sdr_ba,
    output logic [SDR_ADDR_W-1:0] sdr_addr
);

    localparam int              PW_W      = $clog2(PWRUP_CYC + 1);
    localparam logic [PW_W-1:0] PWR_LOAD  = PW_W'(PWRUP_CYC - 1);
    localparam logic [2:0]      AREF_LAST = 3'(NUM_AREF - 1);
    localparam logic [3:0]      MRD_LOAD  = 4'(TMRD - 1);

    localparam logic [3:0] CMD_DESEL = 4'b1111;
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_PRE,
        S_WAIT_TRP,
        S_AREF,
        S_WAIT_TRCAR,
        S_MRS,
        S_WAIT_MRD,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [PW_W-1:0]         pwr_cnt;
    logic [3:0]              sp_cnt;
    logic [2:0]              aref_cnt;
    logic [3:0]              trp_m1;
    logic [3:0]              trcar_m1;

    logic                    cke_nxt;
    logic                    done_nxt;
    logic [3:0]              cmd_nxt;
    logic [1:0]              ba_nxt;
    logic [SDR_ADDR_W-1:0]   addr_nxt;

    // Next state plus the decode of the command bus for the cycle after the edge.
    // Outputs are a function of state_nxt so they register in step with the state.
    always_comb begin
        state_nxt = state;
        cke_nxt   = 1'b1;
        done_nxt  = 1'b0;
        cmd_nxt   = CMD_NOP;
        ba_nxt    = 2'b00;
        addr_nxt  = '0;

        case (state)
            S_IDLE:       state_nxt = S_PWRUP;
            S_PWRUP:      if (pwr_cnt == '0) state_nxt = S_PRE;
            S_PRE,
            S_WAIT_TRP:   state_nxt = (sp_cnt == 4'd0) ? S_AREF : S_WAIT_TRP;
            S_AREF,
            S_WAIT_TRCAR: begin
                if (sp_cnt != 4'd0)              state_nxt = S_WAIT_TRCAR;
                else if (aref_cnt == AREF_LAST)  state_nxt = S_MRS;
                else                             state_nxt = S_AREF;
            end
            S_MRS,
            S_WAIT_MRD:   state_nxt = (sp_cnt == 4'd0) ? S_DONE : S_WAIT_MRD;
            S_DONE:       state_nxt = S_DONE;
            default:      state_nxt = S_IDLE;
        endcase

        // Enable low overrides everything: abort to IDLE without a partial command.
        if (!cfg_sdr_en) state_nxt = S_IDLE;

        case (state_nxt)
            S_IDLE: begin
                cke_nxt = 1'b0;
                cmd_nxt = CMD_DESEL;
            end
            S_PRE: begin
                cmd_nxt      = CMD_PRE;
                addr_nxt[10] = 1'b1;
            end
            S_AREF:  cmd_nxt = CMD_AREF;
            S_MRS: begin
                cmd_nxt  = CMD_MRS;
                addr_nxt = SDR_ADDR_W'(cfg_sdr_mode_reg);
            end
            S_DONE:  done_nxt = 1'b1;
            default: cmd_nxt = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timing latch (stored as N-1 with 0 treated as 1) and the three counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwr_cnt  <= PWR_LOAD;
            sp_cnt   <= 4'd0;
            aref_cnt <= 3'd0;
            trp_m1   <= 4'd0;
            trcar_m1 <= 4'd0;
        end else begin
            if (state == S_IDLE && state_nxt == S_PWRUP) begin
                trp_m1   <= (cfg_sdr_trp_d   == 4'd0) ? 4'd0 : cfg_sdr_trp_d   - 4'd1;
                trcar_m1 <= (cfg_sdr_trcar_d == 4'd0) ? 4'd0 : cfg_sdr_trcar_d - 4'd1;
            end

            if (state == S_IDLE)
                pwr_cnt <= PWR_LOAD;
            else if (state == S_PWRUP && pwr_cnt != '0)
                pwr_cnt <= pwr_cnt - 1'b1;

            // Loaded with spacing-1 on the edge that issues a command; the next
            // command goes out when it has drained to zero.
            case (state_nxt)
                S_PRE:   sp_cnt <= trp_m1;
                S_AREF:  sp_cnt <= trcar_m1;
                S_MRS:   sp_cnt <= MRD_LOAD;
                default: if (sp_cnt != 4'd0) sp_cnt <= sp_cnt - 4'd1;
            endcase

            // aref_cnt holds the index of the most recent AREF (0-based), so it
            // never exceeds NUM_AREF-1 and cannot wrap.
            if (state_nxt == S_PRE)
                aref_cnt <= 3'd0;
            else if (state_nxt == S_AREF && (state == S_AREF || state == S_WAIT_TRCAR))
                aref_cnt <= aref_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sdr_init_done <= 1'b0;
            sdr_cke       <= 1'b0;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_DESEL;
            sdr_ba        <= 2'b00;
            sdr_addr      <= '0;
        end else begin
            sdr_init_done <= done_nxt;
            sdr_cke       <= cke_nxt;
            {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} <= cmd_nxt;
            sdr_ba        <= ba_nxt;
            sdr_addr      <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_sdr_init_seq.sv
// Bench for sdr_init_seq: two instances (NUM_AREF=2 and NUM_AREF=4) share stimulus.
// Expected command events come from an arithmetic timeline model and are queued per instance;
// a negedge monitor pops and compares each observed command / init_done rise.
module tb_sdr_init_seq;

    localparam int PWRUP = 100;
    localparam int TMRD  = 2;
    localparam int BIG   = 32'h7fff_ffff;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_DES  = 4'b1111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;
    localparam logic [3:0] C_DONE = 4'b1110;   // queue marker for the init_done rise

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [12:0] addr;
        logic [1:0] ba;
    } ev_t;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [12:0] mode;
    logic [3:0]  trp;
    logic [3:0]  trcar;

    logic        init_done [2];
    logic        cke       [2];
    logic        cs_n      [2];
    logic        ras_n     [2];
    logic        cas_n     [2];
    logic        we_n      [2];
    logic [1:0]  ba        [2];
    logic [12:0] addr      [2];

    ev_t exp_q [2][$];
    int  n_aref    [2] = '{2, 4};
    int  done_edge [2] = '{BIG, BIG};
    int  run_start = BIG;
    int  run_stop  = BIG;
    int  edge_cnt  = 0;
    int  n_chk     = 0;
    int  n_fail    = 0;

    sdr_init_seq #(.PWRUP_CYC(PWRUP), .NUM_AREF(2), .TMRD(TMRD), .SDR_ADDR_W(13)) dut0 (
        .clk(clk), .reset_n(reset_n), .cfg_sdr_en(en), .cfg_sdr_mode_reg(mode),
        .cfg_sdr_trp_d(trp), .cfg_sdr_trcar_d(trcar), .sdr_init_done(init_done[0]),
        .sdr_cke(cke[0]), .sdr_cs_n(cs_n[0]), .sdr_ras_n(ras_n[0]), .sdr_cas_n(cas_n[0]),
        .sdr_we_n(we_n[0]), .sdr_ba(ba[0]), .sdr_addr(addr[0])
    );

    sdr_init_seq #(.PWRUP_CYC(PWRUP), .NUM_AREF(4), .TMRD(TMRD), .SDR_ADDR_W(13)) dut1 (
        .clk(clk), .reset_n(reset_n), .cfg_sdr_en(en), .cfg_sdr_mode_reg(mode),
        .cfg_sdr_trp_d(trp), .cfg_sdr_trcar_d(trcar), .sdr_init_done(init_done[1]),
        .sdr_cke(cke[1]), .sdr_cs_n(cs_n[1]), .sdr_ras_n(ras_n[1]), .sdr_cas_n(cas_n[1]),
        .sdr_we_n(we_n[1]), .sdr_ba(ba[1]), .sdr_addr(addr[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d edge %0d: got %0h, expected %0h", nm, d, edge_cnt, act, exp);
        end
    endtask

    // Timeline model: en sampled at edge s; PRE after PWRUP edges, then each command
    // follows the previous by its spacing (0 counts as 1); done TMRD after MRS.
    task automatic push_run(input int s, input int t_rp, input int t_rc, input logic [12:0] m);
        int t;
        int sp_rp;
        int sp_rc;
        sp_rp = (t_rp == 0) ? 1 : t_rp;
        sp_rc = (t_rc == 0) ? 1 : t_rc;
        for (int d = 0; d < 2; d++) begin
            t = s + PWRUP;
            exp_q[d].push_back('{t, C_PRE, 13'h400, 2'b00});
            t = t + sp_rp;
            for (int i = 0; i < n_aref[d]; i++) begin
                exp_q[d].push_back('{t, C_AREF, 13'h000, 2'b00});
                t = t + sp_rc;
            end
            exp_q[d].push_back('{t, C_MRS, m, 2'b00});
            done_edge[d] = t + TMRD;
            exp_q[d].push_back('{t + TMRD, C_DONE, 13'h000, 2'b00});
        end
        run_start = s;
        run_stop  = BIG;
    endtask

    // Called at a negedge: drives config and raises enable for the next edge.
    task automatic start_run(input int t_rp, input int t_rc, input logic [12:0] m_drv,
                             input logic [12:0] m_exp, output int s);
        trp   = 4'(t_rp);
        trcar = 4'(t_rc);
        mode  = m_drv;
        en    = 1'b1;
        s     = edge_cnt + 1;
        push_run(s, t_rp, t_rc, m_exp);
    endtask

    // Called at a negedge: drops enable; anything due at or after the next edge never happens.
    task automatic stop_run();
        int f;
        en = 1'b0;
        f = edge_cnt + 1;
        run_stop = f;
        for (int d = 0; d < 2; d++)
            while (exp_q[d].size() > 0 && exp_q[d][$].cyc >= f) void'(exp_q[d].pop_back());
    endtask

    task automatic wait_until(input int k);
        while (edge_cnt < k) @(negedge clk);
    endtask

    task automatic take_event(input int d, input int k, input logic [3:0] c,
                              input logic [12:0] a, input logic [1:0] b);
        ev_t e;
        if (exp_q[d].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event dut%0d edge %0d: got cmd %b, expected no event", d, k, c);
        end else begin
            e = exp_q[d].pop_front();
            chk("event_edge", d, 32'(k), 32'(e.cyc));
            chk("event_cmd",  d, 32'(c), 32'(e.cmd));
            chk("event_addr", d, 32'(a), 32'(e.addr));
            chk("event_ba",   d, 32'(b), 32'(e.ba));
        end
    endtask

    // Monitor / scoreboard.
    initial begin
        logic       prev_done [2];
        logic [3:0] c;
        logic       act;
        int         k;
        prev_done[0] = 1'b0;
        prev_done[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                k = edge_cnt;
                c = {cs_n[d], ras_n[d], cas_n[d], we_n[d]};
                if (reset_n) begin
                    act = (k >= run_start) && (k < run_stop);
                    chk("cke", d, 32'(cke[d]), 32'(act));
                    chk("init_done", d, 32'(init_done[d]), 32'(act && k >= done_edge[d]));
                    if (!act)
                        chk("idle_bus", d, 32'({c, ba[d], addr[d]}), 32'({C_DES, 2'b00, 13'h000}));
                    else if (c == C_NOP)
                        chk("nop_bus", d, 32'({ba[d], addr[d]}), 32'd0);
                    while (exp_q[d].size() > 0 && exp_q[d][0].cyc < k) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL missed_event dut%0d: cmd %b due edge %0d, not observed by edge %0d",
                                 d, exp_q[d][0].cmd, exp_q[d][0].cyc, k);
                        void'(exp_q[d].pop_front());
                    end
                    if (c != C_NOP && c != C_DES)
                        take_event(d, k, c, addr[d], ba[d]);
                    if (init_done[d] && !prev_done[d])
                        take_event(d, k, C_DONE, 13'h000, 2'b00);
                end
                prev_done[d] = init_done[d];
            end
        end
    end

    // Stimulus.
    initial begin
        int s;
        int s2;
        int ra;
        int rb;
        int len;
        logic [12:0] rm;

        reset_n = 1'b0;
        en      = 1'b0;
        mode    = 13'h000;
        trp     = 4'd0;
        trcar   = 4'd0;

        #12;
        for (int d = 0; d < 2; d++) begin
            chk("reset_done", d, 32'(init_done[d]), 32'd0);
            chk("reset_cke",  d, 32'(cke[d]), 32'd0);
            chk("reset_bus",  d, 32'({cs_n[d], ras_n[d], cas_n[d], we_n[d], ba[d], addr[d]}),
                32'({C_DES, 2'b00, 13'h000}));
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal: trp=2, trcar=7, mode 033.
        start_run(2, 7, 13'h033, 13'h033, s);
        wait_until(done_edge[1] + 2);
        stop_run();
        repeat (3) @(negedge clk);

        // Zero spacing: commands back to back.
        start_run(0, 0, 13'h033, 13'h033, s);
        wait_until(done_edge[1] + 2);
        stop_run();
        repeat (3) @(negedge clk);

        // Latching: trcar change during PWRUP ignored; mode change before MRS taken.
        start_run(2, 7, 13'h033, 13'h022, s);
        wait_until(s + 50);
        trcar = 4'd3;
        wait_until(s + 115);
        mode = 13'h022;
        wait_until(done_edge[1] + 2);
        stop_run();
        repeat (3) @(negedge clk);

        // Enable dropped mid-sequence, then re-raised.
        start_run(2, 7, 13'h033, 13'h033, s);
        wait_until(s + 104);
        stop_run();
        @(negedge clk);
        chk("drop_cke", 0, 32'(cke[0]), 32'd0);
        wait_until(s + 109);
        start_run(2, 7, 13'h033, 13'h033, s2);
        wait_until(done_edge[1] + 2);

        // Asynchronous reset while in DONE, mid-cycle, enable held high.
        #2;
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_done", d, 32'(init_done[d]), 32'd0);
            chk("async_rst_cke",  d, 32'(cke[d]), 32'd0);
            chk("async_rst_bus",  d, 32'({cs_n[d], ras_n[d], cas_n[d], we_n[d], ba[d], addr[d]}),
                32'({C_DES, 2'b00, 13'h000}));
            exp_q[d].delete();
            done_edge[d] = BIG;
        end
        run_start = BIG;
        run_stop  = BIG;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        push_run(edge_cnt + 1, 2, 7, 13'h033);
        wait_until(done_edge[1] + 2);
        stop_run();
        repeat (3) @(negedge clk);

        // Randomized runs, some aborted at a random point.
        for (int r = 0; r < 8; r++) begin
            ra = int'($urandom_range(0, 15));
            rb = int'($urandom_range(0, 15));
            rm = 13'($urandom);
            start_run(ra, rb, rm, rm, s);
            len = done_edge[1] - s + 2;
            if ($urandom_range(0, 2) == 0)
                wait_until(s + int'($urandom_range(1, 32'(len))));
            else
                wait_until(done_edge[1] + 2);
            stop_run();
            repeat (3) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("queue_empty", 0, 32'(exp_q[0].size()), 32'd0);
        chk("queue_empty", 1, 32'(exp_q[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sdr_init_seq.md
Name: sdr_init_seq

Overview:
- Slave-side consumer of the SDRAM configuration bundle: cfg_sdr_en, cfg_sdr_mode_reg, cfg_sdr_trp_d and cfg_sdr_trcar_d.
- Runs the JEDEC SDRAM power-up sequence on the SDRAM command bus, then asserts sdr_init_done back to the configuration master.
- Sits between the configuration block and the command mux in front of the SDRAM pads. It owns the command bus until init completes.

Parameters:
- PWRUP_CYC, 100, NOP cycles held with CKE high before the first precharge.
- NUM_AREF, 2, number of auto-refresh commands issued during init (1..8).
- TMRD, 2, cycles from the MRS command to sdr_init_done.
- SDR_ADDR_W, 13, SDRAM address width.

Ports:
- clk  in  1  controller clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cfg_sdr_en  in  1  start/hold enable; while low the block is idle.
- cfg_sdr_mode_reg  in  13  mode register value driven onto sdr_addr during MRS.
- cfg_sdr_trp_d  in  4  precharge-to-next-command spacing, in cycles.
- cfg_sdr_trcar_d  in  4  auto-refresh-to-next-command spacing, in cycles.
- sdr_init_done  out  1  init complete; level signal.
- sdr_cke  out  1  clock enable.
- sdr_cs_n  out  1  chip select.
- sdr_ras_n  out  1  RAS.
- sdr_cas_n  out  1  CAS.
- sdr_we_n  out  1  write enable.
- sdr_ba  out  2  bank address.
- sdr_addr  out  SDR_ADDR_W  address.

Behaviour:
- Reset:
  - All outputs are registered.
  - Reset values: sdr_init_done=0, sdr_cke=0, DESELECT (cs_n=1, ras_n=cas_n=we_n=1), sdr_ba=0, sdr_addr=0.
  - State goes to IDLE.
  - Reset mid-sequence restarts from IDLE with no partial command emitted.
- Command encodings {cs_n,ras_n,cas_n,we_n}:
  - NOP=0111
  - PRE=0010, with addr[10]=1 (all banks), ba=0
  - AREF=0001
  - MRS=0000, with addr=cfg_sdr_mode_reg, ba=0
- Command width: each command is driven for exactly one cycle. Every non-command cycle after IDLE is NOP with addr=0, ba=0.
- Spacing rule: the next command is issued exactly N cycles after the previous one, where N is the latched cfg value. N=0 is treated as 1.
- Latching: trp_d and trcar_d are latched on the IDLE->PWRUP transition. Later changes to these inputs have no effect until the next start. mode_reg is sampled in the MRS cycle.
- States:
  - IDLE: DESELECT, cke=0. Moves to PWRUP when cfg_sdr_en=1.
  - PWRUP: cke=1, NOP for exactly PWRUP_CYC cycles, then PRE.
  - PRE: one cycle, then WAIT_TRP.
  - WAIT_TRP: NOP until trp spacing is met, then AREF.
  - AREF: one cycle. Increments the refresh counter (3 bits, counting from 0), then WAIT_TRCAR.
  - WAIT_TRCAR: NOP until trcar spacing is met. Goes to AREF if fewer than NUM_AREF refreshes have been issued, else MRS.
  - MRS: one cycle, then WAIT_MRD.
  - WAIT_MRD: NOP for TMRD cycles. sdr_init_done is set on the cycle exactly TMRD after MRS, then DONE.
  - DONE: sdr_init_done=1, cke=1, NOP. Stays here while cfg_sdr_en=1.
- cfg_sdr_en low in any non-IDLE state: go to IDLE on the next cycle, with init_done=0, cke=0 and DESELECT. No command is issued in that cycle. Re-asserting cfg_sdr_en restarts the full sequence, including PWRUP.
- Counters:
  - Power-up counter is sized by $clog2(PWRUP_CYC+1).
  - Spacing counter is 4 bits and loaded with N-1 on command issue.
  - No wrap-around is permitted. Counters saturate at 0.

Test Plan:
- Nominal sequence:
  - Stimulus: defaults, trp=2, trcar=7, mode_reg=13'h033, cfg_sdr_en rises and is sampled at edge 0.
  - Response: cke=1 from cycle 1. PRE at cycle 101 with addr[10]=1. AREF at 103 and 110. MRS at 117 with addr=13'h033, ba=0. sdr_init_done=1 from 119 and held.
- Zero spacing:
  - Stimulus: trp=0, trcar=0.
  - Response: PRE, AREF, AREF and MRS on consecutive cycles 101..104. Done at 106.
- Latching of timing inputs:
  - Stimulus: change trcar from 7 to 3 during PWRUP.
  - Response: AREF spacing is still 7.
  - Stimulus: change mode_reg to 13'h022 at cycle 116.
  - Response: MRS carries 13'h022.
- Enable dropped mid-sequence:
  - Stimulus: drop cfg_sdr_en at cycle 105, re-raise at 110.
  - Response: DESELECT and cke=0 from 106. No MRS occurs. The new PRE occurs exactly PWRUP_CYC+1 cycles after the re-raise sample edge.
- Asynchronous reset:
  - Stimulus: assert reset_n low asynchronously in DONE, mid-cycle.
  - Response: init_done=0, cke=0 and DESELECT immediately, without waiting for a clock edge. After release with cfg_sdr_en held at 1, the full sequence repeats with identical timing.
- NUM_AREF=4:
  - Stimulus: NUM_AREF=4, trp=2, trcar=7.
  - Response: exactly 4 AREFs (103, 110, 117, 124). MRS at 131, done at 133.
